mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory/writeback stage on the consumer side of the execute-stage handshake.
- Accepts execute results (exe_valid plus data, address and flags) and issues loads/stores to the data-memory port.
- Back-pressures the execute stage through mem_blocked while a memory access is outstanding.
- Presents one writeback per accepted instruction to the register file.

Parameters:
- ADDR_W, 64, memory address width
- DATA_W, 64, data/result width
- TIMEOUT, 1024, max cycles waiting on req_ready/resp_valid before abort

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exe_valid  in  1  execute output valid (exe_mem)
- exe_result  in  DATA_W  ALU result (store data for stores)
- exe_addr  in  ADDR_W  effective address
- exe_rflags  in  64  flags produced by execute
- exe_is_load  in  1  instruction is a load
- exe_is_store  in  1  instruction is a store
- exe_size  in  2  access size: 0=1B,1=2B,2=4B,3=8B
- exe_sext  in  1  sign-extend load data
- exe_dest  in  4  destination GPR index
- exe_wr_en  in  1  instruction writes exe_dest
- mem_blocked  out  1  stall to execute stage
- req_valid  out  1  memory request valid
- req_addr  out  ADDR_W  request address
- req_write  out  1  1=store, 0=load
- req_size  out  2  request size
- req_wdata  out  DATA_W  store data
- req_ready  in  1  memory accepts request
- resp_valid  in  1  load data returned
- resp_data  in  DATA_W  load data, right-aligned
- wb_valid  out  1  writeback strobe, one cycle
- wb_dest  out  4  writeback register
- wb_wr_en  out  1  register write enable
- wb_data  out  DATA_W  writeback value
- wb_rflags  out  64  flags to commit
- mem_err  out  1  sticky timeout error

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; timeout counter 0; mem_err cleared. Reset mid-access drops the transaction with no writeback; the memory side must tolerate an abandoned request.
- States: IDLE, REQ, WAIT, DONE.
- mem_blocked = (state==REQ || state==WAIT), decoded combinationally from registered state. Execute holds its outputs while it is high.
- Accept: an input is consumed at a posedge only when state is IDLE or DONE and exe_valid=1. Back-to-back acceptance from DONE is required.
- Non-memory accept (no load, no store):
  - Next cycle: wb_valid=1, wb_data=exe_result, wb_dest, wb_wr_en, wb_rflags captured; state=DONE.
  - Latency 1; mem_blocked stays low.
- Load/store accept: capture all fields; state=REQ.
- REQ:
  - req_valid=1, with req_addr/req_write/req_size/req_wdata stable until handshake.
  - req_valid && req_ready at a posedge: store → DONE; load → WAIT.
  - req_valid drops the cycle after the handshake.
- WAIT:
  - resp_valid at a posedge: extract the low 8·2^size bits of resp_data, zero- or sign-extend per exe_sext, register into wb_data; state=DONE.
  - resp_valid seen in any other state is ignored.
- DONE:
  - wb_valid=1 for exactly one cycle (load: wb_data=load value; store: wb_wr_en=0).
  - Without a new accept, state returns to IDLE with wb_valid=0.
- Minimum latencies: load 3 cycles (accept → REQ → WAIT → DONE, with req_ready and resp_valid both immediate); store 2 cycles.
- Timeout:
  - Counter clears on entry to REQ and on leaving WAIT; increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT-1: mem_err=1 (sticky until reset), req_valid=0, state=DONE, writeback issued with wb_wr_en=0.
- exe_is_load and exe_is_store both 1: treated as store.
- Size 3 ignores exe_sext.

Decomposition:
- Shared package (mem_pkg):
  - access-size enum (SZ_B, SZ_W, SZ_D, SZ_Q)
  - stage-state enum
  - writeback bundle struct {valid, dest, wr_en, data, rflags}
- Sub-module load_align: combinational size/sign extraction of resp_data. Reused later by the store-to-load forwarding path.

Test Plan:
- ALU op: exe_valid=1, exe_result=0x2A, exe_dest=3, exe_wr_en=1 → next cycle wb_valid=1, wb_data=0x2A, wb_dest=3; mem_blocked never high.
- Load 4B with sign extension: exe_addr=0x1000, size=2, sext=1; req_ready immediate; resp_data=0x00000000_80000001 one cycle later → wb_data=0xFFFFFFFF_80000001, total latency 3; mem_blocked high exactly 2 cycles.
- Store with stalled memory: exe_result=0xDEAD, size=1; req_ready held low 5 cycles → req_valid and req_addr stable throughout, mem_blocked high 6 cycles, wb_valid pulse with wb_wr_en=0.
- Back-to-back: load followed by ALU op held by execute → ALU op accepted on the DONE edge; wb_valid pulses on consecutive cycles, in order.
- Timeout: TIMEOUT=16, req_ready never asserted → mem_err=1 after 16 cycles, req_valid=0, single wb_valid with wb_wr_en=0, state returns to IDLE.
- Reset during WAIT: reset=1 one cycle → all outputs 0 next cycle; a late resp_valid produces no writeback.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory/writeback stage: access sizes, stage states
// and the writeback bundle presented to the register file.
package mem_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_W = 2'd1,
    SZ_D = 2'd2,
    SZ_Q = 2'd3
  } acc_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } stage_state_e;

  typedef struct packed {
    logic            valid;
    logic [3:0]      dest;
    logic            wr_en;
    logic [XLEN-1:0] data;
    logic [63:0]     rflags;
  } wb_bundle_t;

endpackage

// File: rtl/load_align.sv
// Combinational extraction of a right-aligned load value: keeps the low
// 8*2^size bits and zero- or sign-extends them. Full-width loads pass through.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw_i,
  input  acc_size_e         size_i,
  input  logic              sext_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_B:    data_o = {{(DATA_W-8){sext_i & raw_i[7]}}, raw_i[7:0]};
      SZ_W:    data_o = {{(DATA_W-16){sext_i & raw_i[15]}}, raw_i[15:0]};
      SZ_D:    data_o = {{(DATA_W-32){sext_i & raw_i[31]}}, raw_i[31:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory/writeback stage: accepts execute results, performs one load/store
// handshake on the data-memory port and emits one writeback per instruction.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_valid,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [63:0]       exe_rflags,
  input  logic              exe_is_load,
  input  logic              exe_is_store,
  input  logic [1:0]        exe_size,
  input  logic              exe_sext,
  input  logic [3:0]        exe_dest,
  input  logic              exe_wr_en,
  output logic              mem_blocked,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_write,
  output logic [1:0]        req_size,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              wb_valid,
  output logic [3:0]        wb_dest,
  output logic              wb_wr_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [63:0]       wb_rflags,
  output logic              mem_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  stage_state_e      state_q;
  logic [CNT_W-1:0]  tmo_q;
  logic              req_valid_q;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  acc_size_e         req_size_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              sext_q;
  logic              wr_en_q;
  logic              err_q;
  wb_bundle_t        wb_q;
  logic [DATA_W-1:0] load_data;

  load_align #(.DATA_W(DATA_W)) u_align (
    .raw_i  (resp_data),
    .size_i (req_size_q),
    .sext_i (sext_q),
    .data_o (load_data)
  );

  // Handshake: the execute stage is consumed on any posedge where
  // exe_valid is high and mem_blocked is low; it holds its outputs otherwise.
  // The memory request is offered while req_valid is high and completes on
  // the first posedge with req_ready high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_size_q  <= SZ_B;
      req_wdata_q <= '0;
      sext_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
      wb_q        <= '0;
    end else begin
      wb_q.valid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (exe_valid) begin
            wb_q.dest   <= exe_dest;
            wb_q.rflags <= exe_rflags;
            wb_q.data   <= exe_result;
            if (exe_is_load || exe_is_store) begin
              state_q     <= ST_REQ;
              tmo_q       <= '0;
              req_valid_q <= 1'b1;
              req_write_q <= exe_is_store;
              req_addr_q  <= exe_addr;
              req_size_q  <= acc_size_e'(exe_size);
              req_wdata_q <= exe_result;
              sext_q      <= exe_sext;
              wr_en_q     <= exe_wr_en & ~exe_is_store;
              wb_q.wr_en  <= 1'b0;
            end else begin
              state_q    <= ST_DONE;
              wb_q.valid <= 1'b1;
              wb_q.wr_en <= exe_wr_en;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          tmo_q <= tmo_q + 1'b1;
          if (req_ready) begin
            req_valid_q <= 1'b0;
            if (req_write_q) begin
              state_q    <= ST_DONE;
              wb_q.valid <= 1'b1;
              wb_q.wr_en <= 1'b0;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q       <= 1'b1;
            req_valid_q <= 1'b0;
            state_q     <= ST_DONE;
            wb_q.valid  <= 1'b1;
            wb_q.wr_en  <= 1'b0;
            tmo_q       <= '0;
          end
        end
        ST_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (resp_valid) begin
            wb_q.data  <= load_data;
            wb_q.wr_en <= wr_en_q;
            wb_q.valid <= 1'b1;
            state_q    <= ST_DONE;
            tmo_q      <= '0;
          end else if (tmo_q == TMO_LAST) begin
            // Abandoned load: commit flags but never write the register.
            err_q      <= 1'b1;
            state_q    <= ST_DONE;
            wb_q.valid <= 1'b1;
            wb_q.wr_en <= 1'b0;
            tmo_q      <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_blocked = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign req_valid   = req_valid_q;
  assign req_addr    = req_addr_q;
  assign req_write   = req_write_q;
  assign req_size    = req_size_q;
  assign req_wdata   = req_wdata_q;
  assign wb_valid    = wb_q.valid;
  assign wb_dest     = wb_q.dest;
  assign wb_wr_en    = wb_q.wr_en;
  assign wb_data     = wb_q.data;
  assign wb_rflags   = wb_q.rflags;
  assign mem_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written corner
// sequences and randomized traffic against an in-bench reference model.
module tb_mem_stage;

  localparam int TMO   = 16;
  localparam int EXP_W = 134;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid;
  logic [63:0] exe_result;
  logic [63:0] exe_addr;
  logic [63:0] exe_rflags;
  logic        exe_is_load;
  logic        exe_is_store;
  logic [1:0]  exe_size;
  logic        exe_sext;
  logic [3:0]  exe_dest;
  logic        exe_wr_en;
  logic        mem_blocked;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        wb_wr_en;
  logic [63:0] wb_data;
  logic [63:0] wb_rflags;
  logic        mem_err;
  logic [1:0]  dbg_state;

  mem_stage #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_result(exe_result), .exe_addr(exe_addr),
    .exe_rflags(exe_rflags), .exe_is_load(exe_is_load), .exe_is_store(exe_is_store),
    .exe_size(exe_size), .exe_sext(exe_sext), .exe_dest(exe_dest), .exe_wr_en(exe_wr_en),
    .mem_blocked(mem_blocked), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_wr_en(wb_wr_en), .wb_data(wb_data),
    .wb_rflags(wb_rflags), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exe_valid = 1'b0; exe_result = '0; exe_addr = '0; exe_rflags = '0;
    exe_is_load = 1'b0; exe_is_store = 1'b0; exe_size = 2'd0; exe_sext = 1'b0;
    exe_dest = 4'd0; exe_wr_en = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
  endtask

  task automatic check_all_zero();
    check("rst_mem_blocked", 64'(mem_blocked), 0);
    check("rst_req_valid",   64'(req_valid), 0);
    check("rst_req_addr",    req_addr, 0);
    check("rst_wb_valid",    64'(wb_valid), 0);
    check("rst_wb_data",     wb_data, 0);
    check("rst_wb_dest",     64'(wb_dest), 0);
    check("rst_wb_wr_en",    64'(wb_wr_en), 0);
    check("rst_wb_rflags",   wb_rflags, 0);
    check("rst_mem_err",     64'(mem_err), 0);
    check("rst_state",       64'(dbg_state), 0);
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_all_zero();
    reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  // entry: {check_data, wr_en, dest[3:0], data[63:0], rflags[63:0]}
  logic [EXP_W-1:0] exp_q[$];
  int               wb_cyc_q[$];
  int               blk_cnt = 0;
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_blocked) blk_cnt++;
      if (wb_valid) begin
        wb_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(wb_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("wb_wr_en",  64'(wb_wr_en), 64'(e[132]));
          check("wb_dest",   64'(wb_dest), 64'(e[131:128]));
          check("wb_rflags", wb_rflags, e[63:0]);
          if (e[133]) check("wb_data", wb_data, e[127:64]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input int size, input logic sx);
    int bits;
    logic [63:0] mask;
    logic [63:0] v;
    if (size == 3) return raw;
    bits = 8 << size;
    mask = (64'd1 << bits) - 64'd1;
    v = raw & mask;
    if (sx && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                       input logic [63:0] res, input logic [63:0] addr, input logic [63:0] flags,
                       input logic [3:0] dst, input logic we, output int acc_cyc);
    int n;
    exe_is_load = ld; exe_is_store = st; exe_size = sz; exe_sext = sx;
    exe_result = res; exe_addr = addr; exe_rflags = flags; exe_dest = dst; exe_wr_en = we;
    exe_valid = 1'b1;
    resp_valid = 1'($urandom_range(0, 1));
    resp_data = {$urandom, $urandom};
    n = 0;
    while (mem_blocked && n < 100) begin
      step();
      n++;
    end
    if (n == 100) check("accept_timeout", 64'(mem_blocked), 0);
    step();
    acc_cyc = cyc;
    exe_valid = 1'b0;
    resp_valid = 1'b0;
    exe_result = {$urandom, $urandom}; exe_addr = {$urandom, $urandom};
    exe_rflags = {$urandom, $urandom}; exe_dest = 4'($urandom); exe_size = 2'($urandom);
    exe_sext = 1'($urandom); exe_wr_en = 1'($urandom);
  endtask

  task automatic run_txn(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [63:0] res, input logic [63:0] addr, input logic [63:0] flags,
                         input logic [63:0] resp, input logic [63:0] expd,
                         input logic [3:0] dst, input logic we,
                         input int rdly, input int pdly, output int acc_cyc);
    if (!(ld || st))  exp_q.push_back({1'b1, we, dst, res, flags});
    else if (st)      exp_q.push_back({1'b0, 1'b0, dst, res, flags});
    else              exp_q.push_back({1'b1, we, dst, expd, flags});
    issue(ld, st, sz, sx, res, addr, flags, dst, we, acc_cyc);
    if (ld || st) begin
      for (int i = 0; i <= rdly; i++) begin
        check("req_valid", 64'(req_valid), 1);
        check("req_addr",  req_addr, addr);
        check("req_write", 64'(req_write), 64'(st));
        check("req_size",  64'(req_size), 64'(sz));
        if (st) check("req_wdata", req_wdata, res);
        if (i == rdly) req_ready = 1'b1;
        step();
      end
      req_ready = 1'b0;
      check("req_drop", 64'(req_valid), 0);
      if (!st) begin
        for (int j = 0; j < pdly; j++) step();
        resp_valid = 1'b1;
        resp_data = resp;
        step();
        resp_valid = 1'b0;
        resp_data = {$urandom, $urandom};
      end
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [63:0] res;
    logic [63:0] resp;
    logic [63:0] expd;
    logic [3:0]  dst;
    logic        we;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    int kind, sz, rd, pd;
    logic sx, we;
    logic [63:0] res, resp, addr;

    vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 64'h2A, 64'h0, 64'h2A, 4'd3, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 2'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 4'd15, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 64'h0, 64'h1234_5678_9ABC_DE80, 64'hFFFF_FFFF_FFFF_FF80, 4'd1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h0, 64'h1234_5678_9ABC_DE80, 64'h0000_0000_0000_0080, 4'd2, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 64'h0, 64'hAAAA_BBBB_CCCC_7FFF, 64'h0000_0000_0000_7FFF, 4'd4, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 64'h0, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_FFFF_8001, 4'd5, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b1, 64'h0, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001, 4'd6, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h0, 64'hFFFF_FFFF_8000_0001, 64'h0000_0000_8000_0001, 4'd7, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd8, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 4'd9, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 1'b1, 64'hCAFE, 64'h0, 64'h0, 4'd10, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF, 4'd0, 1'b0};

    reset_dut();

    // vector table, immediate memory
    foreach (vecs[k])
      run_txn(vecs[k].ld, vecs[k].st, vecs[k].sz, vecs[k].sx, vecs[k].res,
              {$urandom, $urandom}, {$urandom, $urandom}, vecs[k].resp, vecs[k].expd,
              vecs[k].dst, vecs[k].we, 0, 0, acc);
    step(); step();

    // ALU op: latency 1, never blocked
    blk_cnt = 0; wb_cyc_q.delete();
    run_txn(1'b0, 1'b0, 2'd0, 1'b0, 64'h2A, 64'h0, 64'h5, 64'h0, 64'h0, 4'd3, 1'b1, 0, 0, acc);
    step(); step();
    check("alu_wb_count", 64'(wb_cyc_q.size()), 1);
    if (wb_cyc_q.size() > 0) check("alu_latency", 64'(wb_cyc_q[0] - acc + 1), 1);
    check("alu_blocked", 64'(blk_cnt), 0);

    // load 4B sign-extended: latency 3, blocked 2
    blk_cnt = 0; wb_cyc_q.delete();
    run_txn(1'b1, 1'b0, 2'd2, 1'b1, 64'h0, 64'h1000, 64'h77, 64'h0000_0000_8000_0001,
            64'hFFFF_FFFF_8000_0001, 4'd6, 1'b1, 0, 0, acc);
    step(); step();
    check("ld_wb_count", 64'(wb_cyc_q.size()), 1);
    if (wb_cyc_q.size() > 0) check("ld_latency", 64'(wb_cyc_q[0] - acc + 1), 3);
    check("ld_blocked", 64'(blk_cnt), 2);

    // store with 5 stalled cycles
    blk_cnt = 0; wb_cyc_q.delete();
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 64'hDEAD, 64'h2000, 64'h99, 64'h0, 64'h0, 4'd2, 1'b1, 5, 0, acc);
    step(); step();
    check("st_blocked", 64'(blk_cnt), 6);
    check("st_wb_count", 64'(wb_cyc_q.size()), 1);
    if (wb_cyc_q.size() > 0) check("st_latency", 64'(wb_cyc_q[0] - acc + 1), 7);

    // back-to-back: load then ALU accepted on the DONE edge
    wb_cyc_q.delete();
    run_txn(1'b1, 1'b0, 2'd0, 1'b0, 64'h0, 64'h3000, 64'h1, 64'hAB, 64'hAB, 4'd11, 1'b1, 0, 1, acc);
    run_txn(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'h0, 64'h2, 64'h0, 64'h0, 4'd12, 1'b1, 0, 0, acc2);
    step(); step();
    check("b2b_wb_count", 64'(wb_cyc_q.size()), 2);
    if (wb_cyc_q.size() == 2) begin
      check("b2b_accept_on_done", 64'(acc2), 64'(wb_cyc_q[0] + 1));
      check("b2b_consecutive", 64'(wb_cyc_q[1]), 64'(wb_cyc_q[0] + 1));
    end

    // timeout: req_ready never asserted
    blk_cnt = 0; wb_cyc_q.delete();
    exp_q.push_back({1'b0, 1'b0, 4'd13, 64'h0, 64'h4242});
    issue(1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 64'h4000, 64'h4242, 4'd13, 1'b1, acc);
    for (int i = 0; i < TMO; i++) begin
      check("tmo_req_hold", 64'(req_valid), 1);
      check("tmo_err_early", 64'(mem_err), 0);
      step();
    end
    check("tmo_err_set", 64'(mem_err), 1);
    check("tmo_req_drop", 64'(req_valid), 0);
    check("tmo_state_done", 64'(dbg_state), 3);
    step();
    check("tmo_state_idle", 64'(dbg_state), 0);
    check("tmo_blocked", 64'(blk_cnt), TMO);
    check("tmo_wb_count", 64'(wb_cyc_q.size()), 1);
    run_txn(1'b0, 1'b0, 2'd0, 1'b0, 64'h55, 64'h0, 64'h3, 64'h0, 64'h0, 4'd1, 1'b1, 0, 0, acc);
    step();
    check("tmo_err_sticky", 64'(mem_err), 1);

    // reset during WAIT drops the load; a late response is ignored
    reset_dut();
    issue(1'b1, 1'b0, 2'd2, 1'b0, 64'h0, 64'h5000, 64'h8, 4'd7, 1'b1, acc);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check("rw_state_wait", 64'(dbg_state), 2);
    reset = 1'b1;
    step();
    check_all_zero();
    reset = 1'b0;
    wb_cyc_q.delete();
    resp_valid = 1'b1; resp_data = 64'h1111;
    step();
    resp_valid = 1'b0;
    step(); step();
    check("rw_no_wb", 64'(wb_cyc_q.size()), 0);

    // randomized traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      sz   = $urandom_range(0, 3);
      sx   = 1'($urandom);
      we   = 1'($urandom);
      rd   = $urandom_range(0, 4);
      pd   = $urandom_range(0, 4);
      res  = {$urandom, $urandom};
      resp = {$urandom, $urandom};
      addr = {$urandom, $urandom};
      run_txn(kind == 1 || kind == 3, kind >= 2, 2'(sz), sx, res, addr, {$urandom, $urandom},
              resp, ref_load(resp, sz, sx), 4'($urandom), we, rd, pd, acc);
      if ($urandom_range(0, 3) == 0) begin
        resp_valid = 1'b1;
        step(); step();
        resp_valid = 1'b0;
      end
    end
    step(); step(); step();
    check("exp_q_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
